// File: rtl/spm_mem_arbiter_pkg.sv
// spm_mem_arbiter_pkg: shared owner encoding and RISC_SPM memory geometry
package spm_mem_arbiter_pkg;
   localparam int WORD_SIZE = 8;
   localparam int ADDR_SIZE = 8;
   typedef enum logic [1:0] {
      OWN_IDLE = 2'b00,
      OWN_CPU  = 2'b01,
      OWN_HOST = 2'b10
   } own_e;
endpackage

// File: rtl/spm_mem_arbiter.sv
// spm_mem_arbiter: round-robin CPU/host arbiter for the single-port RISC_SPM memory
module spm_mem_arbiter
   import spm_mem_arbiter_pkg::*;
#(
   parameter int word_size = WORD_SIZE,
   parameter int addr_size = ADDR_SIZE,
   parameter int LOCK_MAX  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [addr_size-1:0] cpu_addr,
   input  logic [word_size-1:0] cpu_wdata,
   output logic                 cpu_gnt,
   output logic                 cpu_rvalid,
   output logic [word_size-1:0] cpu_rdata,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [addr_size-1:0] host_addr,
   input  logic [word_size-1:0] host_wdata,
   input  logic                 host_lock,
   output logic                 host_gnt,
   output logic                 host_rvalid,
   output logic [word_size-1:0] host_rdata,
   output logic [addr_size-1:0] mem_addr,
   output logic [word_size-1:0] mem_wdata,
   output logic                 mem_we,
   output logic                 mem_re,
   input  logic [word_size-1:0] mem_rdata
);
   own_e                 state_q, state_d;
   logic                 last_host_q, last_host_d;
   logic [3:0]           lock_cnt_q, lock_cnt_d;
   logic                 cpu_rvalid_q, cpu_rvalid_d, host_rvalid_q, host_rvalid_d;
   logic [word_size-1:0] cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;
   logic                 both, lock_hold;

   assign cpu_gnt     = state_q == OWN_CPU;
   assign host_gnt    = state_q == OWN_HOST;
   assign mem_addr    = cpu_gnt ? cpu_addr : host_gnt ? host_addr : '0;
   assign mem_wdata   = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : '0;
   assign mem_we      = (cpu_gnt & cpu_we) | (host_gnt & host_we);
   assign mem_re      = (cpu_gnt & ~cpu_we) | (host_gnt & ~host_we);
   assign cpu_rvalid  = cpu_rvalid_q;
   assign host_rvalid = host_rvalid_q;
   assign cpu_rdata   = cpu_rvalid_q ? mem_rdata : cpu_rdata_q;
   assign host_rdata  = host_rvalid_q ? mem_rdata : host_rdata_q;

   // next owner with round-robin tie break, capped host lock, read-return tracking
   always_comb begin
      both      = cpu_req & host_req;
      lock_hold = both & host_lock & (state_q == OWN_HOST) & (lock_cnt_q < 4'(LOCK_MAX - 1));
      state_d   = lock_hold ? OWN_HOST
                : both      ? (last_host_q ? OWN_CPU : OWN_HOST)
                : cpu_req   ? OWN_CPU
                : host_req  ? OWN_HOST
                :             OWN_IDLE;
      last_host_d   = (state_d == OWN_HOST) ? 1'b1 : (state_d == OWN_CPU) ? 1'b0 : last_host_q;
      lock_cnt_d    = (!host_lock || state_d == OWN_CPU) ? 4'd0
                    : lock_hold ? lock_cnt_q + 4'd1 : lock_cnt_q;
      cpu_rvalid_d  = cpu_gnt & ~cpu_we;
      host_rvalid_d = host_gnt & ~host_we;
      cpu_rdata_d   = cpu_rdata;
      host_rdata_d  = host_rdata;
   end

   // owner, pointer, lock counter and read-return registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= OWN_IDLE;
         last_host_q   <= 1'b1;
         lock_cnt_q    <= 4'd0;
         cpu_rvalid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
         cpu_rdata_q   <= '0;
         host_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         last_host_q   <= last_host_d;
         lock_cnt_q    <= lock_cnt_d;
         cpu_rvalid_q  <= cpu_rvalid_d;
         host_rvalid_q <= host_rvalid_d;
         cpu_rdata_q   <= cpu_rdata_d;
         host_rdata_q  <= host_rdata_d;
      end
   end
endmodule

// File: tb/tb_spm_mem_arbiter.sv
// tb_spm_mem_arbiter: directed and random checks of the memory arbiter against a reference model
module tb_spm_mem_arbiter;
   localparam int LOCK_MAX = 4;

   logic       clk = 1'b0, rst = 1'b0, init_en = 1'b1;
   logic       cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
   logic [7:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
   logic       cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_we, mem_re;
   logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 0;
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];

   int vectors = 0, miscompares = 0;
   int exp_own, exp_prev, last_own, fcnt, exp_crd, exp_hrd;
   bit exp_crv, exp_hrv;

   spm_mem_arbiter #(.word_size(8), .addr_size(8), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(int i);
      return (i == 130) ? 8'd2 : 8'(i * 37 + 5);
   endfunction

   // 256 x 8 synchronous-read memory array
   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         if (mem_re) mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_own = 0; exp_prev = 0; last_own = 2; fcnt = 0;
      exp_crv = 0; exp_hrv = 0; exp_crd = 0; exp_hrd = 0;
   endtask

   task automatic check();
      int ea, ed, ewe, ere;
      ea  = exp_own == 1 ? int'(cpu_addr) : exp_own == 2 ? int'(host_addr) : 0;
      ed  = exp_own == 1 ? int'(cpu_wdata) : exp_own == 2 ? int'(host_wdata) : 0;
      ewe = exp_own == 1 ? int'(cpu_we) : exp_own == 2 ? int'(host_we) : 0;
      ere = exp_own == 0 ? 0 : 1 - ewe;
      chk("cpu_gnt", 32'(cpu_gnt), int'(exp_own == 1));
      chk("host_gnt", 32'(host_gnt), int'(exp_own == 2));
      chk("mem_addr", 32'(mem_addr), ea);
      chk("mem_wdata", 32'(mem_wdata), ed);
      chk("mem_we", 32'(mem_we), ewe);
      chk("mem_re", 32'(mem_re), ere);
      chk("cpu_rvalid", 32'(cpu_rvalid), int'(exp_crv));
      chk("host_rvalid", 32'(host_rvalid), int'(exp_hrv));
      chk("cpu_rdata", 32'(cpu_rdata), exp_crd);
      chk("host_rdata", 32'(host_rdata), exp_hrd);
   endtask

   task automatic update();
      int nxt;
      bit c, h, forced;
      if (!rst) begin
         model_reset();
         return;
      end
      exp_crv = exp_own == 1 && !cpu_we;
      exp_hrv = exp_own == 2 && !host_we;
      if (exp_crv) exp_crd = ref_mem[cpu_addr];
      if (exp_hrv) exp_hrd = ref_mem[host_addr];
      if (exp_own == 1 && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (exp_own == 2 && host_we) ref_mem[host_addr] = host_wdata;
      c = cpu_req; h = host_req;
      forced = c && h && host_lock && exp_own == 2 && fcnt < LOCK_MAX - 1;
      if (forced) nxt = 2;
      else if (c && h) nxt = (last_own == 2) ? 1 : 2;
      else nxt = c ? 1 : h ? 2 : 0;
      if (nxt != 0) last_own = nxt;
      if (!host_lock || nxt == 1) fcnt = 0;
      else if (forced) fcnt++;
      exp_prev = exp_own;
      exp_own = nxt;
   endtask

   task automatic cyc();
      @(negedge clk);
      check();
      @(posedge clk);
      update();
      #1;
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      #2;
      chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("rst_host_gnt", 32'(host_gnt), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_re", 32'(mem_re), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_host_rvalid", 32'(host_rvalid), 0);
      @(posedge clk);
      #1;
      init_en = 0;
      rst = 1;

      cpu_req = 1; cpu_we = 0; cpu_addr = 130;
      cyc();
      chk("t1_gnt", 32'(cpu_gnt), 1);
      chk("t1_host_idle", 32'(host_gnt), 0);
      cpu_req = 0;
      cyc();
      chk("t1_rvalid", 32'(cpu_rvalid), 1);
      chk("t1_rdata", 32'(cpu_rdata), 2);
      chk("t1_host_rvalid", 32'(host_rvalid), 0);
      cyc();
      chk("t1_rvalid_pulse", 32'(cpu_rvalid), 0);
      chk("t1_rdata_hold", 32'(cpu_rdata), 2);

      host_req = 1; host_we = 1; host_addr = 0; host_wdata = 8'h51;
      cyc();
      chk("t2_gnt0", 32'(host_gnt), 1);
      chk("t2_we0", 32'(mem_we), 1);
      cyc();
      host_addr = 1; host_wdata = 130; host_req = 0;
      #1;
      chk("t2_gnt1", 32'(host_gnt), 1);
      chk("t2_we1", 32'(mem_we), 1);
      chk("t2_addr1", 32'(mem_addr), 1);
      cyc();
      chk("t2_idle", 32'(host_gnt), 0);
      cpu_req = 1; cpu_addr = 0;
      cyc();
      cpu_req = 0;
      cyc();
      chk("t2_readback", 32'(cpu_rdata), 'h51);
      cyc();

      cpu_req = 1; cpu_addr = 1;
      cyc();
      chk("t5_gnt", 32'(cpu_gnt), 1);
      cpu_req = 0;
      #2;
      rst = 0;
      #1;
      chk("t5_cpu_gnt", 32'(cpu_gnt), 0);
      chk("t5_mem_re", 32'(mem_re), 0);
      chk("t5_mem_addr", 32'(mem_addr), 0);
      chk("t5_cpu_rdata", 32'(cpu_rdata), 0);
      chk("t5_cpu_rvalid", 32'(cpu_rvalid), 0);
      model_reset();
      cyc();
      chk("t5_no_rvalid", 32'(cpu_rvalid), 0);
      cyc();
      rst = 1;

      cpu_req = 1; cpu_addr = 130; host_req = 1; host_we = 0; host_addr = 1;
      cyc();
      chk("t3_first_tie", 32'(cpu_gnt), 1);
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("t3_alt_cpu", 32'(cpu_gnt), int'(i % 2 == 1));
         chk("t3_alt_host", 32'(host_gnt), int'(i % 2 == 0));
      end
      cpu_req = 0; host_req = 0;
      cyc();
      cyc();

      host_req = 1; host_lock = 1; host_we = 0; host_addr = 10;
      cyc();
      chk("t4_host_first", 32'(host_gnt), 1);
      cpu_req = 1; cpu_we = 0; cpu_addr = 20;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t4_lock_host", 32'(host_gnt), int'(i != 3));
         chk("t4_lock_cpu", 32'(cpu_gnt), int'(i == 3));
      end
      cpu_req = 0; host_req = 0; host_lock = 0;
      cyc();
      cyc();

      host_req = 1; host_we = 1; host_addr = 128; host_wdata = 6;
      cyc();
      host_req = 0;
      #1;
      chk("t6_we", 32'(mem_we), 1);
      chk("t6_addr", 32'(mem_addr), 128);
      cyc();
      chk("t6_idle_we", 32'(mem_we), 0);
      chk("t6_idle_gnt", 32'(host_gnt), 0);
      cpu_req = 1; cpu_addr = 128;
      cyc();
      cpu_req = 0;
      cyc();
      chk("t6_readback", 32'(cpu_rdata), 6);
      cyc();

      for (int n = 0; n < 400; n++) begin
         if (exp_prev == 1 || (!cpu_req && exp_own != 1)) begin
            cpu_we = 1'($urandom); cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
         end
         if (exp_own == 1 || !cpu_req) cpu_req = 1'($urandom);
         if (exp_prev == 2 || (!host_req && exp_own != 2)) begin
            host_we = 1'($urandom); host_addr = 8'($urandom_range(0, 15)); host_wdata = 8'($urandom);
         end
         if (exp_own == 2 || !host_req) host_req = 1'($urandom);
         if ($urandom_range(0, 15) == 0) host_lock = ~host_lock;
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/spm_mem_arbiter.md
Name: spm_mem_arbiter

Overview:
Arbitrates the single-port 256 x 8 program/data memory of the RISC_SPM between two requesters: the CPU (port 0) and a host/debug loader (port 1).
- The host loads programs and data and inspects results through a real bus, so benches no longer poke memory hierarchically.
- Sits between the CPU memory interface, the host port and the memory array.
- Round-robin arbitration, registered grant, 1-cycle read latency.
- Optional host lock for atomic multi-word program loads, capped against CPU starvation.

Parameters:
word_size, 8, data width of memory and all data ports
addr_size, 8, address width (256 locations)
LOCK_MAX, 4, max consecutive host grants under host_lock while CPU is requesting (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request, held until cpu_gnt seen
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  addr_size  CPU address
cpu_wdata  input  word_size  CPU write data
cpu_gnt  output  1  CPU owns memory this cycle; access performed this cycle
cpu_rvalid  output  1  one-cycle pulse, cpu_rdata valid
cpu_rdata  output  word_size  read data to CPU
host_req  input  1  host access request
host_we  input  1  host write enable
host_addr  input  addr_size  host address
host_wdata  input  word_size  host write data
host_lock  input  1  host requests consecutive-grant priority
host_gnt  output  1  host owns memory this cycle
host_rvalid  output  1  one-cycle pulse, host_rdata valid
host_rdata  output  word_size  read data to host
mem_addr  output  addr_size  memory address
mem_wdata  output  word_size  memory write data
mem_we  output  1  memory write strobe
mem_re  output  1  memory read strobe
mem_rdata  input  word_size  memory read data, valid cycle after mem_re

Behaviour:
- Reset (rst low, async):
  - Owner state = IDLE; all gnt, rvalid, mem_we and mem_re = 0.
  - rdata outputs = 0; last-grant pointer = HOST, so CPU wins the first tie; lock counter = 0.
- FSM states: IDLE, CPU, HOST. The state is the registered owner. cpu_gnt = (state==CPU), host_gnt = (state==HOST).
- Next-state decision, evaluated every cycle from the current-cycle requests:
  - Neither requesting -> IDLE.
  - One requesting -> that one.
  - Both requesting -> the one not granted last, except the host lock rule below.
- Host lock: if host_lock=1, state==HOST, both requesting and lock_cnt < LOCK_MAX-1 -> HOST again.
  - lock_cnt increments on each such forced re-grant.
  - When the cap is hit, CPU is granted next. lock_cnt clears on any CPU grant or when host_lock=0.
- Latency: req sampled at edge n -> gnt high during cycle n+1.
  - mem_* is a combinational mux of the granted port's inputs during the gnt cycle.
  - mem_we = gnt & we; mem_re = gnt & ~we.
  - In IDLE: mem_we = mem_re = 0, mem_addr/mem_wdata = 0.
- Read return: in the cycle after a read grant, rvalid pulses to that requester and rdata is mem_rdata, registered there and held until the next read for that port.
- Write return: no rvalid.
- Requester handshake:
  - Requester keeps req/we/addr/wdata stable until it sees gnt high; the access happens in that gnt cycle.
  - Keeping req high after gnt means a new back-to-back request: one access per cycle maximum.
  - Dropping req while gnt is high is legal; the in-flight access still completes.
- Throughput: with a single requester held high, it gets a grant every cycle. With both requesting and no lock, grants strictly alternate.
- Requester addresses are used unmodified; there is no address arithmetic and no wrap-around.
- Reset mid-access: a pending rvalid is suppressed, outputs go to reset values immediately, and a memory write is not guaranteed.

Decomposition:
- Shared package holds:
  - owner state encoding: OWN_IDLE=2'b00, OWN_CPU=2'b01, OWN_HOST=2'b10
  - default word_size/addr_size constants, shared with RISC_SPM
- Flat single module (~200 lines). No sub-module is warranted; the lock counter is 4 bits, inline.

Test Plan:
- mem[130]=2 preloaded; CPU read addr 130 with cpu_req at edge n -> cpu_gnt cycle n+1, cpu_rvalid and cpu_rdata=2 cycle n+2, host outputs idle.
- Host writes 8'b0101_00_01 to addr 0, then 130 to addr 1 on back-to-back cycles -> two host_gnt cycles, mem_we=1 both; CPU read of addr 0 then returns 8'h51.
- Both requesting continuously, host_lock=0, from reset -> grant order CPU, HOST, CPU, HOST...; reads return to the correct port with no crossover.
- LOCK_MAX=4, host_lock=1, both requesting with host owning -> four consecutive host grants, then one CPU grant, then host resumes.
- rst driven low during a CPU read gnt cycle -> all outputs 0 asynchronously, no cpu_rvalid afterwards; after rst release, first tie goes to CPU.
- Host drops host_req while host_gnt is high -> write to 128 (value 6) completes, next cycle IDLE with mem_we=0.
